// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared scan-code constants, sequencer states and event record for ps2_key_ctrl
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERRF   = 8'hFF;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXTBRK
  } ps2_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
  } ps2_event_t;

  // Keyboard status/error bytes that never form a key event on their own.
  function automatic logic is_status(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) || (b == SC_ECHO) ||
           (b == SC_ERR0) || (b == SC_ERRF) || (b == SC_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// rtl/ps2_scan2ascii.sv - set-2 scan code to lowercase ASCII lookup (used with PS2_KEY_ASCII_EN)
module ps2_scan2ascii (
  input  logic [7:0] code,
  input  logic       ext,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63; 8'h23: ascii = 8'h64;
        8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66; 8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68;
        8'h43: ascii = 8'h69; 8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
        8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F; 8'h4D: ascii = 8'h70;
        8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72; 8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74;
        8'h3C: ascii = 8'h75; 8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
        8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
        8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32; 8'h26: ascii = 8'h33;
        8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35; 8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37;
        8'h3E: ascii = 8'h38; 8'h46: ascii = 8'h39;
        8'h29: ascii = 8'h20; 8'h5A: ascii = 8'h0D; 8'h66: ascii = 8'h08;
        default: ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - scan-code sequencer with held-key tracking and event FIFO
// PS2_KEY_ASCII_EN adds ev_ascii, translated at push time and stored per FIFO entry.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [7:0]                  ev_code,
  output logic                        ev_ext,
  output logic                        ev_brk,
  output logic                        ev_rpt,
`ifdef PS2_KEY_ASCII_EN
  output logic [7:0]                  ev_ascii,
`endif
  output logic                        held_valid,
  output logic [7:0]                  held_code,
  output logic                        held_ext,
  output logic [7:0]                  press_cnt,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  ps2_state_t  state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic        ev_gen, ev_ext_n, ev_brk_n, match, full, push, pop;
  ps2_event_t  ev_new;
  ps2_event_t  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign ev_ext_n = (state == EXT) || (state == EXTBRK);
  assign ev_brk_n = (state == BRK) || (state == EXTBRK);
  assign match    = held_valid && (held_code == rx_data) && (held_ext == ev_ext_n);

  always_comb begin
    ev_gen    = 1'b0;
    state_nxt = state;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == SC_EXT)      state_nxt = EXT;
          else if (rx_data == SC_BRK) state_nxt = BRK;
          else                        ev_gen = !is_status(rx_data);
        end
        EXT: begin
          if (rx_data == SC_BRK)      state_nxt = EXTBRK;
          else if (rx_data != SC_EXT) begin
            ev_gen    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: begin
          ev_gen    = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
      state_nxt = IDLE;
    end
  end

  assign ev_new = '{code: rx_data, ext: ev_ext_n, brk: ev_brk_n, rpt: !ev_brk_n && match};

  assign full     = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign ev_valid = (fifo_level != '0);
  assign pop      = ev_valid && ev_ready;
  assign push     = ev_gen && (!full || pop);

  assign ev_code = ev_valid ? mem[rd_ptr].code : 8'h00;
  assign ev_ext  = ev_valid && mem[rd_ptr].ext;
  assign ev_brk  = ev_valid && mem[rd_ptr].brk;
  assign ev_rpt  = ev_valid && mem[rd_ptr].rpt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      held_valid <= 1'b0;
      held_code  <= 8'h00;
      held_ext   <= 1'b0;
      press_cnt  <= 8'h00;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= (rx_valid || state_nxt == IDLE) ? '0 : tmo_cnt + TW'(1);
      // Held-key and press tracking follow every event, even one the FIFO drops.
      if (ev_gen) begin
        if (!ev_brk_n) begin
          if (!match) begin
            press_cnt  <= press_cnt + 8'd1;
            held_valid <= 1'b1;
            held_code  <= rx_data;
            held_ext   <= ev_ext_n;
          end
        end else if (match) begin
          held_valid <= 1'b0;
        end
        if (!push) overflow <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ev_new;
  end

`ifdef PS2_KEY_ASCII_EN
  logic [7:0] ascii_new;
  logic [7:0] ascii_mem [FIFO_DEPTH];

  ps2_scan2ascii u_scan2ascii (
    .code  (rx_data),
    .ext   (ev_ext_n),
    .ascii (ascii_new)
  );

  always_ff @(posedge clk) begin
    if (push) ascii_mem[wr_ptr] <= ascii_new;
  end

  assign ev_ascii = ev_valid ? ascii_mem[rd_ptr] : 8'h00;
`endif

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - directed and randomized bench for ps2_key_ctrl against a queue-based event model
module tb_ps2_key_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_ext, ev_brk, ev_rpt, held_valid, held_ext, overflow;
  logic [7:0] ev_code, held_code, press_cnt;
  logic [2:0] fifo_level;
`ifdef PS2_KEY_ASCII_EN
  logic [7:0] ev_ascii;
`endif

  int total = 0;
  int bad   = 0;

  logic [10:0] q[$];
  bit          m_ext, m_brk, m_hv, m_he, m_ovf;
  logic [7:0]  m_hc, m_press;
  int          m_idle;

  logic [7:0] pool [10] = '{8'h1C, 8'h1B, 8'h23, 8'h15, 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'h75, 8'h6B};

  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_brk     (ev_brk),
    .ev_rpt     (ev_rpt),
`ifdef PS2_KEY_ASCII_EN
    .ev_ascii   (ev_ascii),
`endif
    .held_valid (held_valid),
    .held_code  (held_code),
    .held_ext   (held_ext),
    .press_cnt  (press_cnt),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ext = 0; m_brk = 0; m_hv = 0; m_he = 0; m_ovf = 0;
    m_hc = 8'h00; m_press = 8'h00; m_idle = 0;
  endtask

  // Applies one received byte to the model; the head has already been popped if consumed.
  task automatic model_byte(input logic [7:0] b);
    bit gen = 0, brk = 0, ext = 0, rpt = 0, same;
    if (m_brk) begin
      gen = 1; brk = 1; ext = m_ext; m_brk = 0; m_ext = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (m_ext) begin
      gen = 1; ext = 1; m_ext = 0;
    end else if (!(b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) gen = 1;
    if (gen) begin
      same = m_hv && (b == m_hc) && (ext == m_he);
      if (!brk) begin
        rpt = same;
        if (!same) begin
          m_press = m_press + 8'd1; m_hv = 1; m_hc = b; m_he = ext;
        end
      end else if (same) m_hv = 0;
      if (q.size() < DEPTH) q.push_back({b, ext, brk, rpt});
      else m_ovf = 1;
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit rdy);
    logic [10:0] head;
    @(negedge clk);
    rx_valid = v; rx_data = d; ev_ready = rdy;
    #1;
    head = (q.size() != 0) ? q[0] : 11'd0;
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
    chk("head_event", 32'({ev_code, ev_ext, ev_brk, ev_rpt}), 32'(head));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("held_valid", 32'(held_valid), 32'(m_hv));
    chk("held_code", 32'(held_code), 32'(m_hc));
    chk("held_ext", 32'(held_ext), 32'(m_he));
    chk("press_cnt", 32'(press_cnt), 32'(m_press));
    if (rdy && q.size() != 0) head = q.pop_front();
    if (v) begin
      m_idle = 0;
      model_byte(d);
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_ext = 0; m_brk = 0; m_idle = 0;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    cycle(1'b1, b, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b0; ev_ready = 1'b0;
    #1;
    chk("rst_ev_valid", 32'(ev_valid), 32'd0);
    chk("rst_head", 32'({ev_code, ev_ext, ev_brk, ev_rpt}), 32'd0);
    chk("rst_held_valid", 32'(held_valid), 32'd0);
    chk("rst_held_code", 32'(held_code), 32'd0);
    chk("rst_held_ext", 32'(held_ext), 32'd0);
    chk("rst_press_cnt", 32'(press_cnt), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    do_reset();

    // Make then break of 1C, consumer always ready
    send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1); idle(3, 1);
    chk("t1_press", 32'(press_cnt), 32'd1);
    chk("t1_held", 32'(held_valid), 32'd0);

    // Extended make/break of 75
    do_reset();
    send(8'hE0, 0); send(8'h75, 0); idle(1, 0);
    chk("t2_head_make", 32'({ev_code, ev_ext, ev_brk, ev_rpt}), 32'({8'h75, 3'b100}));
    chk("t2_held_ext", 32'(held_ext), 32'd1);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1); idle(3, 1);
    chk("t2_held_after", 32'(held_valid), 32'd0);

    // Typematic repeats
    do_reset();
    send(8'h1C, 1); send(8'h1C, 1); send(8'h1C, 1); idle(3, 1);
    chk("t3_press", 32'(press_cnt), 32'd1);

    // Overflow with stalled consumer, then drain
    do_reset();
    send(8'h15, 0); send(8'h16, 0); send(8'h1E, 0); send(8'h26, 0); send(8'h25, 0); idle(1, 0);
    chk("t4_level", 32'(fifo_level), 32'd4);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_press", 32'(press_cnt), 32'd5);
    idle(6, 1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    send(8'h15, 0); send(8'h16, 0); send(8'h1E, 0); send(8'h26, 0);
    send(8'h2E, 1); idle(1, 0);
    chk("t5_level", 32'(fifo_level), 32'd4);
    chk("t5_overflow", 32'(overflow), 32'd0);
    idle(6, 1);

    // Prefix timeout and status byte
    do_reset();
    send(8'hE0, 0); idle(TMO, 0); send(8'h1C, 0); idle(1, 0);
    chk("t6_timeout_head", 32'({ev_code, ev_ext, ev_brk, ev_rpt}), 32'({8'h1C, 3'b000}));
    send(8'hAA, 0); idle(1, 0);
    chk("t6_status_level", 32'(fifo_level), 32'd1);
    idle(2, 1);
    send(8'hE0, 0); idle(TMO - 3, 0); send(8'h1B, 0); idle(1, 0);
    chk("t6_no_timeout_head", 32'({ev_code, ev_ext, ev_brk, ev_rpt}), 32'({8'h1B, 3'b100}));
    idle(2, 1);

    // Reset in the middle of an E0 F0 sequence
    do_reset();
    send(8'hE0, 0); send(8'hF0, 0);
    do_reset();
    send(8'h1C, 0); idle(1, 0);
    chk("t7_head", 32'({ev_code, ev_ext, ev_brk, ev_rpt}), 32'({8'h1C, 3'b000}));
    chk("t7_press", 32'(press_cnt), 32'd1);
    idle(2, 1);

    // press_cnt wraps after 260 distinct presses
    do_reset();
    for (int i = 0; i < 260; i++) send((i % 2) ? 8'h1B : 8'h1C, 1);
    idle(2, 1);
    chk("t8_press_wrap", 32'(press_cnt), 32'd4);

    // Random byte stream with random consumer stalls
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0) send(pool[$urandom_range(0, 9)], 1'($urandom_range(0, 1)));
      else idle(1, 1'($urandom_range(0, 1)));
    end
    idle(8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
